data_memory_lsu: RTL and testbench
==================================

// Module: data_memory_lsu
// PURPOSE
//  Byte-addressable data memory with an integrated RV32 load/store unit.
//  - Supports byte, half and word accesses; loads are sign- or zero-extended.
//  - valid/ready request port; registered response one cycle after accept.
//  - Flags out-of-range and reserved-size accesses.
//  - Optional hardware zero-sweep after reset.
//  - Sits between the core's MEM stage and on-chip RAM.
// PARAMETERS
//  MEMORY_SIZE    4096  bytes of storage; power of two, >= 8; WORDS = MEMORY_SIZE/4
//  ADDR_WIDTH     32    request address width
//  CLEAR_ON_RESET 1     1: zero every word after reset; 0: contents retained
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous, active-low reset
//  req_valid    in   1           request present
//  req_ready    out  1           block can accept a request this cycle
//  req_write    in   1           1 = store, 0 = load
//  req_size     in   2           00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned in   1           loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr     in   ADDR_WIDTH  byte address
//  req_wdata    in   32          store data, right-aligned (bits [7:0] / [15:0] / [31:0])
//  rsp_valid    out  1           response strobe, one cycle per accepted request
//  rsp_rdata    out  32          extended load data; 0 for stores and errors
//  rsp_error    out  1           access rejected; memory is not modified
//  init_done    out  1           high once the block is in RUN
// BEHAVIOUR
//  Reset values (reset=0): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, init_done=0,
//   state=CLEAR, clear counter=0.
//  FSM CLEAR -> RUN:
//   - CLEAR_ON_RESET=1: in CLEAR, one word is zeroed per cycle at index 0..WORDS-1.
//     After the WORDS-th write the block goes to RUN, so init_done rises WORDS cycles
//     after reset is released.
//   - CLEAR_ON_RESET=0: the block moves to RUN one cycle after reset is released.
//  Ready and accept:
//   - req_ready = (state==RUN).
//   - A request is accepted when req_valid && req_ready.
//   - Requests arriving while not ready are dropped and produce no response.
//  Throughput and latency:
//   - One request per cycle in RUN.
//   - rsp_valid is asserted exactly on the cycle after accept.
//   - rsp_valid/rsp_rdata/rsp_error hold for one cycle only; there is no response backpressure.
//  Addressing: word index = req_addr[$clog2(MEMORY_SIZE)-1:2]; lane = req_addr[1:0].
//  Errors (rsp_error=1, no write, rsp_rdata=0):
//   - req_addr >= MEMORY_SIZE (all ADDR_WIDTH bits are compared);
//   - req_size==11.
//  Stores:
//   - byte: writes lane addr[1:0] with wdata[7:0].
//   - half: writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
//   - word: writes all 4 lanes. Unwritten lanes are preserved.
//   - Write commits at the accept edge.
//  Loads:
//   - RAM is read at the accept edge and the selected lanes are extended to 32 bits.
//   - Sign extension uses bit 7 (byte) or bit 15 (half) unless req_unsigned=1.
//   - req_unsigned is ignored for word loads.
//  Back-to-back: a load accepted the cycle after a store to the same word returns the new data.
//  Reset mid-operation:
//   - Outputs return to their reset values at once and the pending response is discarded.
//   - The FSM restarts in CLEAR.
//   - With CLEAR_ON_RESET=1, contents are zero after the next sweep.
// CONFIGURATION
//  Macro DMEM_MISALIGN_ERR_EN controls misaligned accesses (half with addr[0]=1,
//  word with addr[1:0]!=0):
//   - Defined: the access sets rsp_error=1, rsp_rdata=0 and performs no write.
//   - Undefined: misalignment never sets rsp_error. Half accesses use addr[0]=0 and word
//     accesses use addr[1:0]=00 (forced alignment); the access completes normally.
//  Out-of-range and reserved-size errors apply in both builds.
// TESTING
//  T1 Reset sweep: MEMORY_SIZE=64, CLEAR_ON_RESET=1, release reset
//     -> init_done rises 16 cycles later; word load of 0x3C returns 0.
//  T2 Byte/half store merge: SW 0x00 <= 0x11223344; SB 0x01 <= 0xAA; SH 0x02 <= 0xBEEF;
//     LW 0x00 -> rsp_rdata = 0xBEEFAA44.
//  T3 Extension: after T2, LB 0x01 -> 0xFFFFFFAA; LBU 0x01 -> 0x000000AA;
//     LH 0x02 -> 0xFFFFBEEF; LHU 0x02 -> 0x0000BEEF.
//  T4 Errors: SW to 0x1000 (MEMORY_SIZE=4096) -> rsp_error=1, nothing written;
//     req_size=11 -> rsp_error=1, rsp_rdata=0.
//  T5 Misalign: LW 0x102 after SW 0x100 <= 0xCAFEF00D
//     -> DMEM_MISALIGN_ERR_EN defined: rsp_error=1, rsp_rdata=0;
//        undefined: rsp_error=0, rsp_rdata=0xCAFEF00D.
//  T6 Reset mid-stream: assert reset on the cycle after accepting LW
//     -> rsp_valid stays 0, req_ready=0 until the sweep completes, init_done re-rises.

Source files
------------

// File: rtl/data_memory_lsu_if.sv
// Request/response bundle between the core MEM stage (master) and the data memory LSU (slave).
interface data_memory_lsu_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic                  rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  rsp_error;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-addressable data RAM with an RV32 load/store unit and optional zero-sweep after reset.
// DMEM_MISALIGN_ERR_EN: when defined, misaligned half/word accesses are rejected instead of force-aligned.
module data_memory_lsu #(
   parameter int MEMORY_SIZE    = 4096,
   parameter int ADDR_WIDTH     = 32,
   parameter bit CLEAR_ON_RESET = 1'b1
)(
   input  logic             clk,
   input  logic             reset,
   data_memory_lsu_if.slave bus,
   output logic             init_done
);

   localparam int WORDS   = MEMORY_SIZE / 4;
   localparam int BYTE_AW = $clog2(MEMORY_SIZE);
   localparam int IDX_W   = BYTE_AW - 2;

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] clrCnt_q, clrCnt_d;
   logic             clearWe;

   logic             accept;
   logic             outOfRange;
   logic             sizeReserved;
   logic             reqError;
   logic             storeWe;
   logic [IDX_W-1:0] wordIdx;
   logic [1:0]       lane;
   logic [3:0]       byteEn;
   logic [31:0]      wdataLanes;
   logic [31:0]      rdWord;
   logic [31:0]      laneData;
   logic [31:0]      loadData;

   logic             rspValid_q;
   logic             rspError_q;
   logic [31:0]      rspRdata_q;

   logic [31:0]      mem [WORDS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= CLEAR;
         clrCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         clrCnt_q <= clrCnt_d;
      end
   end

   // Sweep writes one zero word per cycle; the last index hands over to RUN.
   always_comb begin
      state_d  = state_q;
      clrCnt_d = clrCnt_q;
      clearWe  = 1'b0;
      case (state_q)
         CLEAR: begin
            if (CLEAR_ON_RESET) begin
               clearWe = 1'b1;
               if (clrCnt_q == IDX_W'(WORDS - 1)) begin
                  state_d  = RUN;
                  clrCnt_d = '0;
               end else begin
                  clrCnt_d = clrCnt_q + IDX_W'(1);
               end
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   assign bus.req_ready = (state_q == RUN);
   assign init_done     = (state_q == RUN);
   assign accept        = bus.req_valid && bus.req_ready;

   assign outOfRange   = {1'b0, bus.req_addr} >= (ADDR_WIDTH + 1)'(MEMORY_SIZE);
   assign sizeReserved = (bus.req_size == 2'b11);
   assign wordIdx      = bus.req_addr[BYTE_AW-1:2];

`ifdef DMEM_MISALIGN_ERR_EN
   logic misaligned;
   assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
   assign reqError   = outOfRange || sizeReserved || misaligned;
`else
   assign reqError   = outOfRange || sizeReserved;
`endif

   // Lane selection force-aligns half/word; in the checked build misaligned ones never reach RAM.
   always_comb begin
      lane       = bus.req_addr[1:0];
      byteEn     = 4'b0000;
      wdataLanes = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            byteEn     = 4'b0001 << lane;
            wdataLanes = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            lane       = {bus.req_addr[1], 1'b0};
            byteEn     = 4'b0011 << lane;
            wdataLanes = {2{bus.req_wdata[15:0]}};
         end
         2'b10: begin
            lane   = 2'b00;
            byteEn = 4'b1111;
         end
         default: begin
            byteEn = 4'b0000;
         end
      endcase
   end

   assign storeWe  = accept && bus.req_write && !reqError;
   assign rdWord   = mem[wordIdx];
   assign laneData = rdWord >> {lane, 3'b000};

   always_comb begin
      loadData = laneData;
      case (bus.req_size)
         2'b00: begin
            loadData = bus.req_unsigned ? {24'h0, laneData[7:0]}
                                        : {{24{laneData[7]}}, laneData[7:0]};
         end
         2'b01: begin
            loadData = bus.req_unsigned ? {16'h0, laneData[15:0]}
                                        : {{16{laneData[15]}}, laneData[15:0]};
         end
         default: begin
            loadData = laneData;
         end
      endcase
   end

   // RAM has no reset so it maps onto storage; the sweep provides the zeroing.
   always_ff @(posedge clk) begin
      if (clearWe) begin
         mem[clrCnt_q] <= '0;
      end else if (storeWe) begin
         for (int b = 0; b < 4; b++) begin
            if (byteEn[b]) begin
               mem[wordIdx][8*b +: 8] <= wdataLanes[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rspValid_q <= 1'b0;
         rspError_q <= 1'b0;
         rspRdata_q <= '0;
      end else begin
         rspValid_q <= accept;
         rspError_q <= accept && reqError;
         rspRdata_q <= (accept && !bus.req_write && !reqError) ? loadData : '0;
      end
   end

   assign bus.rsp_valid = rspValid_q;
   assign bus.rsp_error = rspError_q;
   assign bus.rsp_rdata = rspRdata_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: a 64-byte instance with the reset sweep enabled.
module tb_data_memory_lsu;

   localparam int MEM_SIZE = 64;
   localparam int AW       = 32;
   localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic initDone;

   data_memory_lsu_if #(.ADDR_WIDTH(AW)) bus();

   data_memory_lsu #(
      .MEMORY_SIZE(MEM_SIZE),
      .ADDR_WIDTH(AW),
      .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .init_done(initDone)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        error;
      int          dueCycle;
   } expect_t;

   expect_t expQ[$];
   expect_t e;
   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Drives one request for a single cycle and records the response it must produce next cycle.
   task automatic applyStimulus(input string name, input logic wr, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expRdata, input logic expErr);
      @(negedge clk);
      checkOutput({name, " ready"}, {31'h0, bus.req_ready}, 32'h1);
      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      expQ.push_back('{name, expRdata, expErr, cycle + 1});
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
      end
   endtask

   task automatic waitInit(input string name);
      int n;
      n = 0;
      while (initDone !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
         if (n == 8) begin
            checkOutput({name, " ready during sweep"}, {31'h0, bus.req_ready}, 32'h0);
            bus.req_valid = 1'b0;
         end
      end
      checkOutput({name, " init_done latency"}, n, 32'd16);
      checkOutput({name, " ready after sweep"}, {31'h0, bus.req_ready}, 32'h1);
   endtask

   // Monitor: retires overdue expectations as missing, then matches each response strobe.
   always @(negedge clk) begin
      while (expQ.size() > 0 && expQ[0].dueCycle < cycle) begin
         checkOutput({expQ[0].name, " missing rsp"}, 32'h0, 32'h1);
         void'(expQ.pop_front());
      end
      if (bus.rsp_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected rsp_valid", 32'h1, 32'h0);
         end else begin
            e = expQ.pop_front();
            checkOutput({e.name, " rdata"}, bus.rsp_rdata, e.rdata);
            checkOutput({e.name, " error"}, {31'h0, bus.rsp_error}, {31'h0, e.error});
            checkOutput({e.name, " latency"}, cycle, e.dueCycle);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = SZ_W;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset req_ready", {31'h0, bus.req_ready}, 32'h0);
      checkOutput("reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      checkOutput("reset rsp_rdata", bus.rsp_rdata, 32'h0);
      checkOutput("reset rsp_error", {31'h0, bus.rsp_error}, 32'h0);
      checkOutput("reset init_done", {31'h0, initDone}, 32'h0);

      reset = 1'b1;
      waitInit("sweep1");

      applyStimulus("T1 LW 3C", 1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
      applyStimulus("T1 LW 00", 1'b0, SZ_W, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);

      applyStimulus("T2 SW 00", 1'b1, SZ_W, 1'b0, 32'h00, 32'h11223344, 32'h0, 1'b0);
      applyStimulus("T2 SB 01", 1'b1, SZ_B, 1'b0, 32'h01, 32'h000000AA, 32'h0, 1'b0);
      applyStimulus("T2 SH 02", 1'b1, SZ_H, 1'b0, 32'h02, 32'h0000BEEF, 32'h0, 1'b0);
      applyStimulus("T2 LW 00", 1'b0, SZ_W, 1'b0, 32'h00, 32'h0, 32'hBEEFAA44, 1'b0);

      applyStimulus("T3 LB 01",  1'b0, SZ_B, 1'b0, 32'h01, 32'h0, 32'hFFFFFFAA, 1'b0);
      applyStimulus("T3 LBU 01", 1'b0, SZ_B, 1'b1, 32'h01, 32'h0, 32'h000000AA, 1'b0);
      applyStimulus("T3 LH 02",  1'b0, SZ_H, 1'b0, 32'h02, 32'h0, 32'hFFFFBEEF, 1'b0);
      applyStimulus("T3 LHU 02", 1'b0, SZ_H, 1'b1, 32'h02, 32'h0, 32'h0000BEEF, 1'b0);
      applyStimulus("T3 LB 00",  1'b0, SZ_B, 1'b0, 32'h00, 32'h0, 32'h00000044, 1'b0);
      applyStimulus("T3 LH 00",  1'b0, SZ_H, 1'b0, 32'h00, 32'h0, 32'hFFFFAA44, 1'b0);

      applyStimulus("T4 SW 40",       1'b1, SZ_W, 1'b0, 32'h40,       32'hDEADBEEF, 32'h0, 1'b1);
      applyStimulus("T4 SW 1000",     1'b1, SZ_W, 1'b0, 32'h1000,     32'hDEADBEEF, 32'h0, 1'b1);
      applyStimulus("T4 SB 80000000", 1'b1, SZ_B, 1'b0, 32'h80000000, 32'h00000055, 32'h0, 1'b1);
      applyStimulus("T4 LW 40",       1'b0, SZ_W, 1'b0, 32'h40,       32'h0, 32'h0, 1'b1);
      applyStimulus("T4 LW 00 kept",  1'b0, SZ_W, 1'b0, 32'h00,       32'h0, 32'hBEEFAA44, 1'b0);
      applyStimulus("T4 L rsv",       1'b0, SZ_R, 1'b0, 32'h00,       32'h0, 32'h0, 1'b1);
      applyStimulus("T4 S rsv",       1'b1, SZ_R, 1'b0, 32'h00,       32'hFFFFFFFF, 32'h0, 1'b1);
      applyStimulus("T4 LW 00 again", 1'b0, SZ_W, 1'b0, 32'h00,       32'h0, 32'hBEEFAA44, 1'b0);

      applyStimulus("T5 SW 30", 1'b1, SZ_W, 1'b0, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
      applyStimulus("T5 LW 32",  1'b0, SZ_W, 1'b0, 32'h32, 32'h0, 32'h0, 1'b1);
      applyStimulus("T5 LHU 31", 1'b0, SZ_H, 1'b1, 32'h31, 32'h0, 32'h0, 1'b1);
      applyStimulus("T5 LH 33",  1'b0, SZ_H, 1'b0, 32'h33, 32'h0, 32'h0, 1'b1);
      applyStimulus("T5 SH 33",  1'b1, SZ_H, 1'b0, 32'h33, 32'h00001234, 32'h0, 1'b1);
      applyStimulus("T5 LW 30",  1'b0, SZ_W, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);
`else
      applyStimulus("T5 LW 32",  1'b0, SZ_W, 1'b0, 32'h32, 32'h0, 32'hCAFEF00D, 1'b0);
      applyStimulus("T5 LHU 31", 1'b0, SZ_H, 1'b1, 32'h31, 32'h0, 32'h0000F00D, 1'b0);
      applyStimulus("T5 LH 33",  1'b0, SZ_H, 1'b0, 32'h33, 32'h0, 32'hFFFFCAFE, 1'b0);
      applyStimulus("T5 SH 33",  1'b1, SZ_H, 1'b0, 32'h33, 32'h00001234, 32'h0, 1'b0);
      applyStimulus("T5 LW 30",  1'b0, SZ_W, 1'b0, 32'h30, 32'h0, 32'h1234F00D, 1'b0);
`endif
      applyStimulus("T5 SB 34",  1'b1, SZ_B, 1'b0, 32'h34, 32'h0000005A, 32'h0, 1'b0);
      applyStimulus("T5 LBU 34", 1'b0, SZ_B, 1'b1, 32'h34, 32'h0, 32'h0000005A, 1'b0);
      applyStimulus("T5 LB 37",  1'b0, SZ_B, 1'b0, 32'h37, 32'h0, 32'h00000000, 1'b0);
      applyStimulus("T5 SB 37",  1'b1, SZ_B, 1'b0, 32'h37, 32'h00000080, 32'h0, 1'b0);
      applyStimulus("T5 LB 37b", 1'b0, SZ_B, 1'b0, 32'h37, 32'h0, 32'hFFFFFF80, 1'b0);
      applyStimulus("T5 LW 34",  1'b0, SZ_W, 1'b0, 32'h34, 32'h0, 32'h8000005A, 1'b0);
      idleCycles(3);

      // Reset lands just after the LW is accepted, so its response must never appear.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_size  = SZ_W;
      bus.req_addr  = 32'h00;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("T6 rsp_valid in reset", {31'h0, bus.rsp_valid}, 32'h0);
      checkOutput("T6 rsp_rdata in reset", bus.rsp_rdata, 32'h0);
      checkOutput("T6 ready in reset", {31'h0, bus.req_ready}, 32'h0);
      checkOutput("T6 init_done in reset", {31'h0, initDone}, 32'h0);
      bus.req_write = 1'b1;
      bus.req_wdata = 32'h77777777;
      @(negedge clk);
      reset = 1'b1;
      waitInit("sweep2");
      applyStimulus("T6 LW 00", 1'b0, SZ_W, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
      applyStimulus("T6 LW 30", 1'b0, SZ_W, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);
      applyStimulus("T6 LW 34", 1'b0, SZ_W, 1'b0, 32'h34, 32'h0, 32'h0, 1'b0);
      idleCycles(3);

      checkOutput("pending responses", expQ.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
